// File: rtl/keyboard_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : keyboard_core_if
//  Description : Bundle of the keyboard scanner's enables, SKCTL controls,
//                key-matrix lines and SKSTAT/KBCODE/IRQ-request outputs.
//                The master side is the scanner core; the slave side is the
//                surrounding chip logic and the physical key matrix.
//  Revision    : 1.0  initial release
// ============================================================================
interface keyboard_core_if;
    logic       enn;        // 1.79MHz negative-edge enable
    logic       enp;        // 1.79MHz positive-edge enable (port parity only)
    logic       scanEn;     // SKCTL bit1
    logic       debEn;      // SKCTL bit0
    logic       kr1;        // key return, active-low
    logic       kr2;        // modifier return, active-low
    logic [5:0] kOut;       // matrix scan address
    logic [7:0] kbcode;     // {ctrl, shift, addr}
    logic       keyDown;    // SKSTAT key depressed
    logic       shiftDown;  // SKSTAT shift held
    logic       setKey;     // key IRQ request
    logic       setBreak;   // break IRQ request

    modport master (
        input  enn, enp, scanEn, debEn, kr1, kr2,
        output kOut, kbcode, keyDown, shiftDown, setKey, setBreak
    );

    modport slave (
        output enn, enp, scanEn, debEn, kr1, kr2,
        input  kOut, kbcode, keyDown, shiftDown, setKey, setBreak
    );
endinterface
`default_nettype wire

// File: rtl/keyboard_core.sv
`default_nettype none
// ============================================================================
//  Module      : keyboard_core
//  Description : POKEY keyboard scanner. Walks the 64-key matrix, samples the
//                key and modifier return lines once per scan address,
//                debounces a single tracked key with a two-pass compare FSM,
//                latches KBCODE and raises key/break IRQ request pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module keyboard_core #(
    parameter int SCAN_DIV = 114
) (
    input  logic            clk,
    input  logic            reset_n,
    keyboard_core_if.master kb
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int                 c_DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [5:0]         c_ADDR_CTRL  = 6'h00;
    localparam logic [5:0]         c_ADDR_SHIFT = 6'h10;
    localparam logic [5:0]         c_ADDR_BREAK = 6'h30;

    logic [c_DIV_W-1:0] r_div;
    logic [5:0]         r_addr;
    logic               r_ctrl;
    logic               r_shift;
    logic               r_brk;
    logic               r_setbrk;

    state_t             r_state;
    logic [5:0]         r_cmp;
    logic [7:0]         r_kbcode;
    logic               r_keydown;
    logic               r_setkey;

    state_t             w_state_nxt;
    logic [5:0]         w_cmp_nxt;
    logic [7:0]         w_kbcode_nxt;
    logic               w_keydown_nxt;
    logic               w_accept;

    logic               w_sample;
    logic               w_key;
    logic               w_mod;
    logic               w_match;
    logic               w_brk_evt;
    logic               w_unused_enp;

    // The return lines are active-low; a sample happens on the last enn of each address slot.
    assign w_sample     = kb.enn && (r_div == c_DIV_LAST);
    assign w_key        = ~kb.kr1;
    assign w_mod        = ~kb.kr2;
    assign w_match      = (r_addr == r_cmp);
    assign w_brk_evt    = w_sample && (r_addr == c_ADDR_BREAK) && w_mod && !r_brk;
    assign w_unused_enp = kb.enp;

    assign kb.kOut      = r_addr;
    assign kb.kbcode    = r_kbcode;
    assign kb.keyDown   = r_keydown;
    assign kb.shiftDown = r_shift;
    assign kb.setKey    = r_setkey;
    assign kb.setBreak  = r_setbrk;

    // Scan divider, address walk, modifier latches and the break request pulse.
    always_ff @(posedge clk) begin
        if (!reset_n || !kb.scanEn) begin
            r_div    <= '0;
            r_addr   <= 6'd0;
            r_ctrl   <= 1'b0;
            r_shift  <= 1'b0;
            r_brk    <= 1'b0;
            r_setbrk <= 1'b0;
        end else if (kb.enn) begin
            r_setbrk <= w_brk_evt;
            if (w_sample) begin
                r_div  <= '0;
                r_addr <= r_addr + 6'd1;
                if (r_addr == c_ADDR_CTRL)  r_ctrl  <= w_mod;
                if (r_addr == c_ADDR_SHIFT) r_shift <= w_mod;
                if (r_addr == c_ADDR_BREAK) r_brk   <= w_mod;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    // Debounce FSM register; KBCODE survives a scan disable, everything else is cleared.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cmp     <= 6'd0;
            r_kbcode  <= 8'h00;
            r_keydown <= 1'b0;
            r_setkey  <= 1'b0;
        end else if (!kb.scanEn) begin
            r_state   <= ST_IDLE;
            r_keydown <= 1'b0;
            r_setkey  <= 1'b0;
        end else if (kb.enn) begin
            r_state   <= w_state_nxt;
            r_cmp     <= w_cmp_nxt;
            r_kbcode  <= w_kbcode_nxt;
            r_keydown <= w_keydown_nxt;
            r_setkey  <= w_accept;
        end
    end

    // Next-state logic: outside IDLE only the tracked address is looked at.
    always_comb begin
        w_state_nxt   = r_state;
        w_cmp_nxt     = r_cmp;
        w_kbcode_nxt  = r_kbcode;
        w_keydown_nxt = r_keydown;
        w_accept      = 1'b0;
        if (w_sample) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_key) begin
                        w_cmp_nxt = r_addr;
                        if (kb.debEn) w_state_nxt = ST_CONFIRM;
                        else          w_accept    = 1'b1;
                    end
                end
                ST_CONFIRM: begin
                    if (w_match) begin
                        if (w_key) w_accept    = 1'b1;
                        else       w_state_nxt = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (w_match && !w_key) begin
                        if (kb.debEn) begin
                            w_state_nxt = ST_RELEASE;
                        end else begin
                            w_state_nxt   = ST_IDLE;
                            w_keydown_nxt = 1'b0;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (w_match) begin
                        if (w_key) begin
                            w_state_nxt = ST_HELD;
                        end else begin
                            w_state_nxt   = ST_IDLE;
                            w_keydown_nxt = 1'b0;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
            if (w_accept) begin
                w_kbcode_nxt  = {r_ctrl, r_shift, r_addr};
                w_keydown_nxt = 1'b1;
                w_state_nxt   = ST_HELD;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keyboard_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keyboard_core
//  Description : Self-checking bench for keyboard_core with a key-matrix
//                model, a tick-count reference model, a vector table and
//                directed multi-pass sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_keyboard_core;

    localparam int SD       = 4;
    localparam int PASS_CLK = 64 * SD * 2;   // enn fires every second clk

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_on = 1'b0, ctrl_on = 1'b0, shift_on = 1'b0, brk_on = 1'b0;
    logic [5:0] key_addr = 6'd0;
    bit         chk_en = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    keyboard_core_if kb();

    keyboard_core #(.SCAN_DIV(SD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kb      (kb)
    );

    always #5 clk = ~clk;

    // enn/enp: alternate phases of a half-rate strobe
    initial begin
        kb.enn = 1'b0;
        kb.enp = 1'b1;
        forever begin
            @(negedge clk);
            kb.enn = ~kb.enn;
            kb.enp = ~kb.enn;
        end
    end

    // Key matrix: return lines pulled low when the scan address hits a pressed key
    assign kb.kr1 = !(key_on && (kb.kOut == key_addr));
    assign kb.kr2 = !((ctrl_on  && kb.kOut == 6'h00) ||
                      (shift_on && kb.kOut == 6'h10) ||
                      (brk_on   && kb.kOut == 6'h30));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic run_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    // Position in the scan is just a count of enn ticks since scanning started.
    int         m_ticks = 0;
    int         m_mode = 0;      // 0 idle, 1 awaiting confirm, 2 held, 3 released once
    logic [5:0] m_cmp = 6'd0;
    logic [7:0] m_kbcode = 8'h00;
    bit         m_keydown = 0, m_ctrl = 0, m_shift = 0, m_brk = 0, m_setkey = 0, m_setbrk = 0;

    task automatic model_sample(input int a);
        bit kp;
        bit mp;
        bit acc;
        kp  = key_on && (int'(key_addr) == a);
        mp  = (ctrl_on && a == 0) || (shift_on && a == 16) || (brk_on && a == 48);
        acc = 0;
        if (a == 48) begin
            if (mp && !m_brk) m_setbrk = 1;
            m_brk = mp;
        end
        if (m_mode == 0) begin
            if (kp) begin
                m_cmp = 6'(a);
                if (kb.debEn) m_mode = 1;
                else          acc = 1;
            end
        end else if (int'(m_cmp) == a) begin
            if (m_mode == 1) begin
                if (kp) acc = 1;
                else    m_mode = 0;
            end else if (m_mode == 2) begin
                if (!kp) begin
                    if (kb.debEn) m_mode = 3;
                    else begin m_mode = 0; m_keydown = 0; end
                end
            end else begin
                if (kp) m_mode = 2;
                else begin m_mode = 0; m_keydown = 0; end
            end
        end
        if (acc) begin
            m_kbcode  = {m_ctrl, m_shift, 6'(a)};
            m_keydown = 1;
            m_setkey  = 1;
            m_mode    = 2;
        end
        if (a == 0)  m_ctrl  = mp;
        if (a == 16) m_shift = mp;
    endtask

    always @(posedge clk) begin
        if (!reset_n || !kb.scanEn) begin
            m_ticks = 0; m_mode = 0; m_keydown = 0;
            m_ctrl = 0; m_shift = 0; m_brk = 0; m_setkey = 0; m_setbrk = 0;
            if (!reset_n) m_kbcode = 8'h00;
        end else if (kb.enn) begin
            m_setkey = 0;
            m_setbrk = 0;
            if (m_ticks % SD == SD - 1) model_sample((m_ticks / SD) % 64);
            m_ticks = (m_ticks + 1) % (64 * SD);
        end
    end

    // ---------------- continuous compare and pulse bookkeeping ----------------
    int   sk_rises = 0, sb_rises = 0, sk_cur = 0, sk_last = 0, wraps = 0;
    bit   sk_prev = 0, sb_prev = 0;
    logic [5:0] kout_prev = 6'd0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("model", {14'd0, kb.kOut, kb.kbcode, kb.keyDown, kb.shiftDown, kb.setKey, kb.setBreak},
                  {14'd0, 6'((m_ticks / SD) % 64), m_kbcode, m_keydown, m_shift, m_setkey, m_setbrk});
            if (kb.setKey && !sk_prev) sk_rises++;
            if (kb.setBreak && !sb_prev) sb_rises++;
            if (kb.setKey) sk_cur++;
            else begin
                if (sk_prev) sk_last = sk_cur;
                sk_cur = 0;
            end
            if (kout_prev == 6'd63 && kb.kOut == 6'd0) wraps++;
            sk_prev   = kb.setKey;
            sb_prev   = kb.setBreak;
            kout_prev = kb.kOut;
        end
    end

    typedef struct {
        logic [5:0] key;
        bit         ctrl;
        bit         shift;
        bit         deb;
        logic [7:0] exp_code;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int  r0;
        int  b0;
        bit  found;

        vecs[0] = '{6'h2A, 1'b0, 1'b0, 1'b1, 8'h2A};
        vecs[1] = '{6'h01, 1'b1, 1'b0, 1'b1, 8'h81};
        vecs[2] = '{6'h3F, 1'b1, 1'b1, 1'b0, 8'hFF};
        vecs[3] = '{6'h10, 1'b0, 1'b1, 1'b1, 8'h50};
        vecs[4] = '{6'h00, 1'b1, 1'b1, 1'b0, 8'hC0};
        vecs[5] = '{6'h30, 1'b0, 1'b0, 1'b0, 8'h30};

        kb.scanEn = 1'b1;
        kb.debEn  = 1'b1;
        reset_n   = 1'b0;
        run_clks(3);
        chk_en = 1'b1;
        check("reset_state", {kb.kOut, kb.kbcode, kb.keyDown, kb.shiftDown, kb.setKey, kb.setBreak}, 32'd0);
        reset_n = 1'b1;

        // 1: idle scanning
        run_clks(3 * PASS_CLK + 8);
        check("t1_wraps", wraps, 3);
        check("t1_setkey", sk_rises, 0);
        check("t1_setbreak", sb_rises, 0);
        check("t1_keydown", kb.keyDown, 0);

        // 2: debounced key 0x2A held 3 passes
        key_addr = 6'h2A; key_on = 1'b1;
        r0 = sk_rises;
        run_clks(PASS_CLK);
        check("t2_pass1_setkey", sk_rises - r0, 0);
        run_clks(PASS_CLK);
        check("t2_pass2_setkey", sk_rises - r0, 1);
        run_clks(PASS_CLK);
        check("t2_pass3_setkey", sk_rises - r0, 1);
        check("t2_pulse_width", sk_last, 2);
        check("t2_kbcode", kb.kbcode, 8'h2A);
        check("t2_keydown", kb.keyDown, 1);
        key_on = 1'b0;
        run_clks(PASS_CLK);
        check("t2_keydown_rel1", kb.keyDown, 1);
        run_clks(PASS_CLK);
        check("t2_keydown_rel2", kb.keyDown, 0);

        // 3: bounce of one pass rejected
        r0 = sk_rises;
        key_addr = 6'h15; key_on = 1'b1;
        run_clks(PASS_CLK);
        key_on = 1'b0;
        run_clks(2 * PASS_CLK);
        check("t3_setkey", sk_rises - r0, 0);
        check("t3_kbcode", kb.kbcode, 8'h2A);
        check("t3_keydown", kb.keyDown, 0);

        // 4: no debounce, shift + 0x3F accepted on first sample
        kb.debEn = 1'b0;
        r0 = sk_rises;
        shift_on = 1'b1; key_addr = 6'h3F; key_on = 1'b1;
        run_clks(PASS_CLK + 64);
        check("t4_setkey", sk_rises - r0, 1);
        check("t4_kbcode", kb.kbcode, 8'h7F);
        check("t4_shiftdown", kb.shiftDown, 1);
        check("t4_keydown", kb.keyDown, 1);
        run_clks(PASS_CLK - 64);
        key_on = 1'b0; shift_on = 1'b0;
        run_clks(2 * PASS_CLK);
        check("t4_release", {kb.keyDown, kb.shiftDown}, 2'b00);

        // 5: break, no repeat while held, second pulse after release
        kb.debEn = 1'b1;
        b0 = sb_rises;
        brk_on = 1'b1;
        run_clks(4 * PASS_CLK);
        check("t5_break_held", sb_rises - b0, 1);
        brk_on = 1'b0;
        run_clks(PASS_CLK);
        brk_on = 1'b1;
        run_clks(PASS_CLK);
        check("t5_break_repress", sb_rises - b0, 2);
        brk_on = 1'b0;
        run_clks(PASS_CLK);

        // table-driven keys with modifiers
        for (int i = 0; i < 6; i++) begin
            key_on = 1'b0; ctrl_on = 1'b0; shift_on = 1'b0;
            run_clks(2 * PASS_CLK);
            kb.debEn = vecs[i].deb;
            ctrl_on  = vecs[i].ctrl;
            shift_on = vecs[i].shift;
            run_clks(PASS_CLK);
            r0 = sk_rises;
            key_addr = vecs[i].key;
            key_on   = 1'b1;
            run_clks(3 * PASS_CLK);
            check($sformatf("vec%0d_kbcode", i), kb.kbcode, vecs[i].exp_code);
            check($sformatf("vec%0d_keydown", i), kb.keyDown, 1);
            check($sformatf("vec%0d_setkey", i), sk_rises - r0, 1);
        end
        key_on = 1'b0; ctrl_on = 1'b0; shift_on = 1'b0;
        run_clks(2 * PASS_CLK);

        // 6: scan disable while HELD, then reset in the middle of a setKey pulse
        kb.debEn = 1'b1;
        key_addr = 6'h05; key_on = 1'b1;
        run_clks(2 * PASS_CLK);
        check("t6_held", {kb.kbcode, kb.keyDown}, {8'h05, 1'b1});
        kb.scanEn = 1'b0;
        run_clks(1);
        check("t6_scanoff", {kb.kOut, kb.kbcode, kb.keyDown, kb.setKey}, {6'd0, 8'h05, 1'b0, 1'b0});
        run_clks(9);
        kb.scanEn = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 3 * PASS_CLK && !found; t++) begin
            @(negedge clk);
            if (kb.setKey) found = 1'b1;
        end
        check("t6_setkey_seen", found, 1);
        reset_n = 1'b0;
        run_clks(1);
        check("t6_reset_midpulse", {kb.kOut, kb.kbcode, kb.keyDown, kb.shiftDown, kb.setKey, kb.setBreak}, 32'd0);
        key_on = 1'b0;
        run_clks(2);
        reset_n = 1'b1;

        // randomized stimulus against the reference model
        for (int s = 0; s < 30; s++) begin
            key_on   = 1'($urandom % 2);
            key_addr = 6'($urandom);
            ctrl_on  = ($urandom % 3) == 0;
            shift_on = ($urandom % 3) == 0;
            brk_on   = ($urandom % 3) == 0;
            kb.debEn = 1'($urandom % 2);
            if ($urandom % 8 == 0) begin
                kb.scanEn = 1'b0;
                run_clks($urandom_range(1, 20));
                kb.scanEn = 1'b1;
            end
            run_clks($urandom_range(50, 1200));
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
